// File: rtl/store_result_monitor.sv
// Store-result monitor: watches the core's data-memory write port and latches a
// pass / fail / timeout verdict, along with store and cycle statistics.
module store_result_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd18,
    parameter logic [31:0] PASS_DATA      = 32'd21,
    parameter logic [31:0] FAIL_ADDR      = 32'hFFFF_FFFC,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] write_count,
    output logic [31:0] cycle_count,
    output logic [31:0] last_addr,
    output logic [31:0] last_data
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PASS    = 2'd1,
        S_FAIL    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_e;

    state_e      state_q;
    logic        done_q, pass_q, fail_q, timeout_q;
    logic [15:0] write_count_q, write_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] last_addr_q, last_data_q;
    logic        pass_hit, fail_hit, timeout_hit;

    // Verdict priority: correct signature, then explicit fail address,
    // then wrong signature, then timeout on the post-increment cycle count.
    always_comb begin
        cycle_count_d = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
        write_count_d = (write_count_q == 16'hFFFF) ? write_count_q : write_count_q + 16'd1;
        pass_hit      = memwrite && (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
        fail_hit      = memwrite && ((dataadr == FAIL_ADDR) || (dataadr == PASS_ADDR));
        timeout_hit   = (cycle_count_d == TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            write_count_q <= 16'd0;
            cycle_count_q <= 32'd0;
            last_addr_q   <= 32'd0;
            last_data_q   <= 32'd0;
        end else if (state_q == S_RUN) begin
            cycle_count_q <= cycle_count_d;
            if (memwrite) begin
                write_count_q <= write_count_d;
                last_addr_q   <= dataadr;
                last_data_q   <= writedata;
            end
            if (pass_hit) begin
                state_q <= S_PASS;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
            end else if (fail_hit) begin
                state_q <= S_FAIL;
                done_q  <= 1'b1;
                fail_q  <= 1'b1;
            end else if (timeout_hit) begin
                state_q   <= S_TIMEOUT;
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
        // Terminal states hold every register until reset.
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign write_count = write_count_q;
    assign cycle_count = cycle_count_q;
    assign last_addr   = last_addr_q;
    assign last_data   = last_data_q;

endmodule

// File: tb/tb_store_result_monitor.sv
// Directed bench for store_result_monitor: a per-cycle vector table plus
// hand-written timeout sequences.
module tb_store_result_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        done, pass, fail, timeout;
    logic [15:0] write_count;
    logic [31:0] cycle_count, last_addr, last_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_result_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .write_count(write_count),
        .cycle_count(cycle_count),
        .last_addr  (last_addr),
        .last_data  (last_data)
    );

    // flags = {done, pass, fail, timeout}
    typedef struct {
        logic        rst;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  flags;
        logic [15:0] wc;
        logic [31:0] cc;
        logic [31:0] la;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic mw, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] flags, input logic [15:0] wc,
                       input logic [31:0] cc, input logic [31:0] la, input logic [31:0] ld);
        vec_t v;
        v.rst = rst; v.mw = mw; v.adr = adr; v.dat = dat; v.flags = flags;
        v.wc = wc; v.cc = cc; v.la = la; v.ld = ld;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic mw, input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        reset     = rst;
        memwrite  = mw;
        dataadr   = adr;
        writedata = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] flags, input logic [15:0] wc,
                             input logic [31:0] cc, input logic [31:0] la, input logic [31:0] ld);
        check({tag, " flags"}, {28'd0, done, pass, fail, timeout}, {28'd0, flags});
        check({tag, " write_count"}, {16'd0, write_count}, {16'd0, wc});
        check({tag, " cycle_count"}, cycle_count, cc);
        check({tag, " last_addr"}, last_addr, la);
        check({tag, " last_data"}, last_data, ld);
    endtask

    initial begin
        // Pass after five idle cycles, then hold.
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 4'b0000, 0, i, 0, 0);
        add(0, 1, 18, 21, 4'b1100, 1, 6, 18, 21);
        add(0, 0, 0, 0, 4'b1100, 1, 6, 18, 21);
        add(0, 1, 32'hFFFF_FFFC, 5, 4'b1100, 1, 6, 18, 21);
        // Wrong signature fails; a later correct signature is ignored.
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 84, 7, 4'b0000, 1, 1, 84, 7);
        add(0, 1, 18, 20, 4'b1010, 2, 2, 18, 20);
        add(0, 1, 18, 21, 4'b1010, 2, 2, 18, 20);
        // Full 32-bit address compare: near-miss addresses do not trigger.
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 32'h8000_0012, 21, 4'b0000, 1, 1, 32'h8000_0012, 21);
        add(0, 1, 19, 21, 4'b0000, 2, 2, 19, 21);
        add(0, 1, 32'h7FFF_FFFC, 3, 4'b0000, 3, 3, 32'h7FFF_FFFC, 3);
        // Explicit fail address, then reset colliding with a pass store, then pass.
        add(0, 1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 4'b1010, 4, 4, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        add(1, 1, 18, 21, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 18, 21, 4'b1100, 1, 1, 18, 21);
        // Reset with a store from a terminal state returns to RUN with zeros.
        add(1, 1, 18, 21, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].mw, vecs[i].adr, vecs[i].dat);
            check_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].wc, vecs[i].cc,
                      vecs[i].la, vecs[i].ld);
        end

        // Timeout with no stores: verdict exactly when cycle_count reaches 200.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 199; i++) step(0, 0, 0, 0);
        check_all("to_pre", 4'b0000, 0, 199, 0, 0);
        step(0, 0, 0, 0);
        check_all("to_hit", 4'b1001, 0, 200, 0, 0);
        for (int i = 0; i < 50; i++) step(0, (i == 10), 18, 21);
        check_all("to_hold", 4'b1001, 0, 200, 0, 0);

        // Pass store on the timeout cycle wins over TIMEOUT.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 199; i++) step(0, 0, 0, 0);
        check_all("race_pre", 4'b0000, 0, 199, 0, 0);
        step(0, 1, 18, 21);
        check_all("race_hit", 4'b1100, 1, 200, 18, 21);

        // Wrong-signature store on the timeout cycle also beats TIMEOUT.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 199; i++) step(0, 0, 0, 0);
        step(0, 1, 18, 22);
        check_all("race_fail", 4'b1010, 1, 200, 18, 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
